multi_ch_serializer: RTL and testbench

// - Collects NUM_CH parallel CNN channel streams (e.g. per-filter MaxPool outputs) into per-channel FIFOs.
// - Emits them on one serial stream as complete groups: ch0, ch1, ... ch(NUM_CH-1), then repeats.
// - Successor of the fixed 3-channel/64-deep serializer. Adds: parametrised width/depth/channel count,

---
 rtl/multi_ch_serializer_pkg.sv | 13 +
 rtl/multi_ch_serializer_if.sv | 27 ++
 rtl/multi_ch_serializer_sync_fifo.sv | 48 ++++
 rtl/multi_ch_serializer.sv | 122 ++++++++++++
 tb/tb_multi_ch_serializer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_ch_serializer_pkg.sv
// Shared types and helpers for the multi-channel serializer.
package multi_ch_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GROUP = 1'b1
  } phase_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_ch_serializer_if.sv
// Parallel channel inputs and serial output stream of the serializer.
interface multi_ch_serializer_if
  import multi_ch_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
);
  localparam int CH_W = idx_w(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        vin;
  logic [DATA_W-1:0]        dout;
  logic                     vout;
  logic [CH_W-1:0]          dout_ch;
  logic                     dout_last;
  logic                     out_ready;

  modport master (
    input  din, vin, out_ready,
    output dout, vout, dout_ch, dout_last
  );

  modport slave (
    output din, vin, out_ready,
    input  dout, vout, dout_ch, dout_last
  );
endinterface

// File: rtl/multi_ch_serializer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the caller never pushes when full
// without a same-cycle pop and never pops when empty.
module sync_fifo
  import multi_ch_serializer_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
endmodule

// File: rtl/multi_ch_serializer.sv
// Buffers NUM_CH channel streams and emits them round-robin as complete groups
// on one valid/ready serial stream with channel tag and group-last marker.
//
//   state    | meaning
//   ST_IDLE  | k=0: wait until every FIFO holds a sample, then emit ch0
//   ST_GROUP | k>0: emit ch k; after ch NUM_CH-1 return to ST_IDLE
module multi_ch_serializer
  import multi_ch_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_ch_serializer_if.master  bus,
  output logic [NUM_CH-1:0]      ovf
);
  localparam int              CH_W    = idx_w(NUM_CH);
  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [DATA_W-1:0] head [NUM_CH];
  logic [NUM_CH-1:0] push, pop, full, empty;

  phase_t            state_q, state_d;
  logic [CH_W-1:0]   k_q, k_d, sel;
  logic              load, free;

  logic [DATA_W-1:0] dout_q;
  logic              vout_q;
  logic [CH_W-1:0]   ch_q;
  logic              last_q;

  assign free = !vout_q || bus.out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] count;

    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push[c] = bus.vin[c] && ((count != CNT_W'(DEPTH)) || pop[c]);

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .din   (bus.din[c*DATA_W +: DATA_W]),
      .pop   (pop[c]),
      .dout  (head[c]),
      .count (count),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sel     = k_q;
    load    = 1'b0;
    pop     = '0;
    if (free) begin
      case (state_q)
        ST_IDLE: begin
          if (!(|empty)) begin
            load    = 1'b1;
            sel     = '0;
            pop[0]  = 1'b1;
            k_d     = CH_W'(1);
            state_d = ST_GROUP;
          end
        end
        ST_GROUP: begin
          load     = 1'b1;
          pop[k_q] = 1'b1;
          if (k_q == LAST_CH) begin
            k_d     = '0;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + CH_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      vout_q <= 1'b0;
      ch_q   <= '0;
      last_q <= 1'b0;
      ovf    <= '0;
    end else begin
      ovf <= ovf | (bus.vin & full & ~pop);
      if (free) begin
        vout_q <= load;
        if (load) begin
          dout_q <= head[sel];
          ch_q   <= sel;
          last_q <= (sel == LAST_CH);
        end
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.vout      = vout_q;
  assign bus.dout_ch   = ch_q;
  assign bus.dout_last = last_q;
endmodule

// File: tb/tb_multi_ch_serializer.sv
// Bench for multi_ch_serializer: vector table, corner-case sequences and a
// per-channel model feeding an expected-beat queue.
module tb_multi_ch_serializer;
  import multi_ch_serializer_pkg::*;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] d0, d1, d2;
    logic [7:0] e0, e1, e2;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ovf;

  multi_ch_serializer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  multi_ch_serializer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          beats   = 0;
  beat_t       exp_q [$];
  logic [7:0]  mq [NUM_CH][$];
  logic [2:0]  mov;
  vec_t        vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // scoreboard pop on every accepted beat
  always @(negedge clk) begin
    beat_t e;
    if (!rst && bus.vout && bus.out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_extra: unexpected beat data %0d ch %0d", bus.dout, bus.dout_ch);
      end else begin
        e = exp_q.pop_front();
        check("sb_beat", int'({bus.dout, bus.dout_ch, bus.dout_last}), int'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (dut.pop[c] && dut.empty[c]) begin
          n_total++;
          $display("FAIL pop_empty: ch %0d popped while empty", c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_push(input logic [2:0] v, input logic [7:0] d0, d1, d2);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(d[c]);
        else mov[c] = 1'b1;
      end
    end
    while (mq[0].size() > 0 && mq[1].size() > 0 && mq[2].size() > 0) begin
      for (int c = 0; c < NUM_CH; c++)
        exp_q.push_back({mq[c].pop_front(), 2'(c), (c == NUM_CH - 1)});
    end
  endtask

  task automatic drive_write(input logic [2:0] v, input logic [7:0] d0, d1, d2);
    bus.vin = v;
    bus.din = {d2, d1, d0};
    model_push(v, d0, d1, d2);
    @(posedge clk); #1;
    bus.vin = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    mov = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vin = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic wait_beat(input int ch, input string name);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.vout && int'(bus.dout_ch) == ch) found = 1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: no beat on ch %0d within 50 cycles", name, ch);
    end
  endtask

  initial begin
    int b0, gaps;
    logic [7:0] ek;

    rst = 1'b1;
    bus.vin = '0;
    bus.din = '0;
    bus.out_ready = 1'b1;
    mov = '0;

    vecs[0] = {8'd5,   8'hFD, 8'd7,  8'd5,   8'hFD, 8'd7};
    vecs[1] = {8'h80,  8'h7F, 8'h00, 8'h80,  8'h7F, 8'h00};
    vecs[2] = {8'hFF,  8'hFE, 8'hFD, 8'hFF,  8'hFE, 8'hFD};
    vecs[3] = {8'd1,   8'd2,  8'd3,  8'd1,   8'd2,  8'd3};

    // reset state
    do_reset();
    check("rst_vout", bus.vout, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_ch",   bus.dout_ch, 0);
    check("rst_last", bus.dout_last, 0);
    check("rst_ovf",  ovf, 0);

    // table-driven single groups, exact latency and tagging
    for (int i = 0; i < 4; i++) begin
      drive_write(3'b111, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      check("vec_pre", bus.vout, 0);
      for (int k = 0; k < NUM_CH; k++) begin
        @(posedge clk); #1;
        ek = (k == 0) ? vecs[i].e0 : (k == 1) ? vecs[i].e1 : vecs[i].e2;
        check("vec_vout", bus.vout, 1);
        check("vec_dout", bus.dout, ek);
        check("vec_ch",   bus.dout_ch, k);
        check("vec_last", bus.dout_last, int'(k == NUM_CH - 1));
      end
      @(posedge clk); #1;
      check("vec_idle", bus.vout, 0);
    end

    // incomplete group waits for the missing channel
    do_reset();
    b0 = beats;
    for (int i = 0; i < 4; i++) drive_write(3'b011, 8'(10 + i), 8'(20 + i), 8'd0);
    idle(5);
    check("inc_vout", bus.vout, 0);
    check("inc_beats0", beats - b0, 0);
    drive_write(3'b100, 8'd0, 8'd0, 8'd99);
    idle(8);
    check("inc_beats", beats - b0, 3);
    check("inc_sb_left", exp_q.size(), 0);

    // backpressure mid-group
    do_reset();
    b0 = beats;
    drive_write(3'b111, 8'd1, 8'd2, 8'd3);
    drive_write(3'b111, 8'd4, 8'd5, 8'd6);
    wait_beat(1, "bp_wait");
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_vout", bus.vout, 1);
      check("bp_dout", bus.dout, 2);
      check("bp_ch",   bus.dout_ch, 1);
    end
    bus.out_ready = 1'b1;
    idle(10);
    check("bp_beats", beats - b0, 6);
    check("bp_sb_left", exp_q.size(), 0);

    // overflow on ch1 only
    do_reset();
    b0 = beats;
    for (int i = 0; i < 6; i++) drive_write(3'b010, 8'd0, 8'(40 + i), 8'd0);
    idle(2);
    check("ovf_flag", ovf, 3'b010);
    check("ovf_model", ovf, mov);
    check("ovf_no_out", beats - b0, 0);
    for (int i = 0; i < 4; i++) drive_write(3'b101, 8'(50 + i), 8'd0, 8'(60 + i));
    idle(16);
    check("ovf_beats", beats - b0, 12);
    check("ovf_sb_left", exp_q.size(), 0);
    check("ovf_sticky", ovf, 3'b010);

    // streaming at the sustainable rate: one group in per NUM_CH cycles
    do_reset();
    b0 = beats;
    gaps = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % NUM_CH == 0) begin
        bus.vin = 3'b111;
        bus.din = {8'(i + 2), 8'(i + 1), 8'(i)};
        model_push(3'b111, 8'(i), 8'(i + 1), 8'(i + 2));
      end else begin
        bus.vin = '0;
      end
      @(posedge clk); #1;
      if (i >= 1 && !bus.vout) gaps++;
    end
    bus.vin = '0;
    idle(6);
    check("str_gaps", gaps, 0);
    check("str_beats", beats - b0, 300);
    check("str_sb_left", exp_q.size(), 0);
    check("str_ovf", ovf, 0);

    // reset after the ch0 beat discards the rest of the group
    do_reset();
    drive_write(3'b111, 8'd11, 8'd22, 8'd33);
    wait_beat(0, "rst_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_vout", bus.vout, 0);
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_ch",   bus.dout_ch, 0);
    check("mid_rst_last", bus.dout_last, 0);
    check("mid_rst_ovf",  ovf, 0);
    rst = 1'b0;
    clear_model();
    b0 = beats;
    drive_write(3'b111, 8'hA1, 8'hB2, 8'hC3);
    wait_beat(0, "rst_fresh");
    check("fresh_dout", bus.dout, 8'hA1);
    idle(6);
    check("fresh_beats", beats - b0, 3);
    check("fresh_sb_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
